mem_arbiter: RTL

- Shares the single-port data BRAM (MEM_SIZE words) between requesters: the CPU core's load/store path (LWR/SW), the program loader and a debug reader.
- Round-robin arbitration with one transaction in flight at a time.
- Sequences the BRAM enable, write-enable, address and data signals, and returns read data to the granted requester with a one-hot valid pulse.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arbiter_rr_picker.sv | 31 +++
 rtl/mem_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data-BRAM arbiter.
// Optional bounds check is enabled with MEM_ARB_BOUNDS_CHECK_EN.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2
  } arb_state_t;

  // Width needed to index n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after the last winner.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [PTR_W-1:0] w_cand;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    // Offset NUM_REQ wraps back to the last winner itself, so it is searched last.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      w_cand = PTR_W'((32'(i_ptr) + off) % NUM_REQ);
      if (!o_valid && i_req[w_cand]) begin
        o_valid       = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port data BRAM between requesters.
// Define MEM_ARB_BOUNDS_CHECK_EN to add the ERR output and suppress out-of-range accesses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MEM_SIZE = 1024,
  parameter int READ_LAT = 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ-1:0]        WE,
  input  logic [NUM_REQ*ADDR_W-1:0] ADDR,
  input  logic [NUM_REQ*DATA_W-1:0] WDATA,
  output logic [NUM_REQ-1:0]        GNT,
  output logic [NUM_REQ-1:0]        RVALID,
  output logic [DATA_W-1:0]         RDATA,
  output logic                      BUSY,
  output logic                      MEM_EN,
  output logic                      MEM_WE,
  output logic [ADDR_W-1:0]         MEM_ADDR,
  output logic [DATA_W-1:0]         MEM_WDATA,
  input  logic [DATA_W-1:0]         MEM_RDATA
`ifdef MEM_ARB_BOUNDS_CHECK_EN
  ,
  output logic                      ERR
`endif
);

  localparam int PTR_W = idx_width(NUM_REQ);
  localparam int CNT_W = idx_width(READ_LAT + 1);
  localparam logic [PTR_W-1:0] LP_PTR_RST  = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LP_CNT_LOAD = CNT_W'(READ_LAT);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  arb_state_t         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic               r_mem_en, w_mem_en_nxt;
  logic               r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0]  r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0]  r_mem_wdata, w_mem_wdata_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_wr, w_wr_nxt;
  logic               r_oob, w_oob_nxt;

  logic [NUM_REQ-1:0] w_pick_oh;
  logic [PTR_W-1:0]   w_pick_idx;
  logic               w_pick_vld;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic               w_sel_we;
  logic               w_sel_oob;
  logic               w_last;
  logic               w_arb;
  logic [NUM_REQ-1:0] w_ptr_oh;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .i_req   (REQ),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick_oh),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_vld)
  );

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_we    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_pick_idx == PTR_W'(i)) begin
        w_sel_addr  = ADDR[i*ADDR_W +: ADDR_W];
        w_sel_wdata = WDATA[i*DATA_W +: DATA_W];
        w_sel_we    = WE[i];
      end
    end
  end

`ifdef MEM_ARB_BOUNDS_CHECK_EN
  logic r_err;

  assign w_sel_oob = (32'(w_sel_addr) >= 32'(MEM_SIZE));
  assign ERR       = r_err;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_arb && w_pick_vld && w_sel_oob;
    end
  end
`else
  assign w_sel_oob = 1'b0;
`endif

  // The final RWAIT cycle (RVALID) also arbitrates, so back-to-back reads lose no cycle.
  assign w_last = (r_state == RWAIT) && (r_cnt == LP_CNT_ONE);
  assign w_arb  = (r_state == IDLE) || w_last;

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = '0;
    w_mem_en_nxt    = 1'b0;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_ptr_nxt       = r_ptr;
    w_cnt_nxt       = r_cnt;
    w_wr_nxt        = r_wr;
    w_oob_nxt       = r_oob;
    case (r_state)
      IDLE: ;
      ISSUE: begin
        if (r_wr) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RWAIT;
          w_cnt_nxt   = LP_CNT_LOAD;
        end
      end
      RWAIT: begin
        w_cnt_nxt = r_cnt - LP_CNT_ONE;
        if (w_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_arb && w_pick_vld) begin
      w_state_nxt     = ISSUE;
      w_gnt_nxt       = w_pick_oh;
      w_mem_en_nxt    = !w_sel_oob;
      w_mem_we_nxt    = w_sel_we && !w_sel_oob;
      w_mem_addr_nxt  = w_sel_addr;
      w_mem_wdata_nxt = w_sel_wdata;
      w_ptr_nxt       = w_pick_idx;
      w_wr_nxt        = w_sel_we;
      w_oob_nxt       = w_sel_oob;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ptr       <= LP_PTR_RST;
      r_cnt       <= '0;
      r_wr        <= 1'b0;
      r_oob       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_wr        <= w_wr_nxt;
      r_oob       <= w_oob_nxt;
    end
  end

  // The pointer still holds the in-flight requester while the read is outstanding.
  always_comb begin
    w_ptr_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_ptr == PTR_W'(i)) begin
        w_ptr_oh[i] = 1'b1;
      end
    end
  end

  assign GNT       = r_gnt;
  assign MEM_EN    = r_mem_en;
  assign MEM_WE    = r_mem_we;
  assign MEM_ADDR  = r_mem_addr;
  assign MEM_WDATA = r_mem_wdata;
  assign BUSY      = ((r_state == ISSUE) && !r_wr) || (r_state == RWAIT);
  assign RVALID    = w_last ? w_ptr_oh : '0;
  assign RDATA     = (w_last && !r_oob) ? MEM_RDATA : '0;

endmodule
